// File: rtl/qpsk_demapper_deserializer_if.sv
// Symbol-in / word-out bus of the QPSK demapper-deserializer.
// master = symbol source and word consumer side, slave = the demapper.
interface qpsk_demapper_deserializer_if #(
   parameter int unsigned WORD_BITS = 16
);
   logic                  sym_valid;
   logic signed [1:0]     I_Signal;
   logic signed [1:0]     Q_Signal;
   logic [WORD_BITS-1:0]  word_data;
   logic                  word_valid;
   logic                  word_ready;
   logic                  erasure;
   logic                  overflow;
   logic                  locked;

   modport master (
      output sym_valid, I_Signal, Q_Signal, word_ready,
      input  word_data, word_valid, erasure, overflow, locked
   );

   modport slave (
      input  sym_valid, I_Signal, Q_Signal, word_ready,
      output word_data, word_valid, erasure, overflow, locked
   );
endinterface

// File: rtl/qpsk_demapper_deserializer.sv
// Hard-decision QPSK demapper packing symbol bit pairs LSB-first into words.
// Optional frame-sync hunt/lock FSM enabled by defining SYNC_SEARCH_EN.
module qpsk_demapper_deserializer #(
   parameter int unsigned          WORD_BITS   = 16,
   parameter logic [WORD_BITS-1:0] SYNC_WORD   = WORD_BITS'(16'hB41E),
   parameter int unsigned          ERASE_LIMIT = 4
) (
   input  logic                          CLOCK_50,
   input  logic                          RESET,
   qpsk_demapper_deserializer_if.slave   bus
);
   localparam int unsigned SYMS   = WORD_BITS / 2;
   localparam int unsigned CNT_W  = (SYMS > 1) ? $clog2(SYMS) : 1;
   localparam int unsigned ECNT_W = $clog2(SYMS + 1);

   logic [WORD_BITS-1:0] word_data_q, word_data_d;
   logic                 word_valid_q, word_valid_d;
   logic                 erasure_q, erasure_d;
   logic                 overflow_q, overflow_d;
   logic [WORD_BITS-1:0] asm_q, asm_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [1:0] pair;
   logic       erase;
   logic       hs;
   logic       last_sym;
   logic       asm_en;

   // Negative levels (-1, -2) decide 1; zero on either rail is an erasure.
   assign pair     = {bus.I_Signal[1], bus.Q_Signal[1]};
   assign erase    = (bus.I_Signal == 2'sd0) || (bus.Q_Signal == 2'sd0);
   assign hs       = word_valid_q & bus.word_ready;
   assign last_sym = (cnt_q == CNT_W'(SYMS - 1));

`ifdef SYNC_SEARCH_EN
   localparam logic [0:0] ST_HUNT = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [WORD_BITS-1:0] win_q, win_d;
   logic [ECNT_W-1:0]    ecnt_q, ecnt_d;
   logic                 locked_q, locked_d;

   assign asm_en = (state_q == ST_LOCK);

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state_q  <= ST_HUNT;
         win_q    <= '0;
         ecnt_q   <= '0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         ecnt_q   <= ecnt_d;
         locked_q <= locked_d;
      end
   end

   // Hunt slides a window over the symbol stream; lock drops after an erasure-heavy word.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      ecnt_d  = ecnt_q;
      if (bus.sym_valid) begin
         if (state_q == ST_HUNT) begin
            win_d = {pair, win_q[WORD_BITS-1:2]};
            if (win_d == SYNC_WORD) begin
               state_d = ST_LOCK;
               ecnt_d  = '0;
            end
         end else begin
            ecnt_d = ecnt_q + ECNT_W'(erase);
            if (last_sym) begin
               if (32'(ecnt_d) >= ERASE_LIMIT) begin
                  state_d = ST_HUNT;
                  win_d   = '0;
               end
               ecnt_d = '0;
            end
         end
      end
      locked_d = (state_d == ST_LOCK);
   end

   assign bus.locked = locked_q;
`else
   logic unused_cfg;

   assign unused_cfg = ^{SYNC_WORD, 32'(ERASE_LIMIT)};
   assign asm_en     = 1'b1;
   assign bus.locked = 1'b1;
`endif

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         word_data_q  <= '0;
         word_valid_q <= 1'b0;
         erasure_q    <= 1'b0;
         overflow_q   <= 1'b0;
         asm_q        <= '0;
         cnt_q        <= '0;
      end else begin
         word_data_q  <= word_data_d;
         word_valid_q <= word_valid_d;
         erasure_q    <= erasure_d;
         overflow_q   <= overflow_d;
         asm_q        <= asm_d;
         cnt_q        <= cnt_d;
      end
   end

   // Pairs shift in from the top, so after SYMS symbols symbol 0 sits at bits [1:0].
   always_comb begin
      word_data_d  = word_data_q;
      word_valid_d = word_valid_q;
      overflow_d   = overflow_q;
      erasure_d    = 1'b0;
      asm_d        = asm_q;
      cnt_d        = cnt_q;
      if (hs) begin
         word_valid_d = 1'b0;
      end
      if (bus.sym_valid) begin
         erasure_d = erase;
      end
      if (bus.sym_valid && asm_en) begin
         asm_d = {pair, asm_q[WORD_BITS-1:2]};
         if (last_sym) begin
            cnt_d = '0;
            if (!word_valid_q || hs) begin
               word_data_d  = asm_d;
               word_valid_d = 1'b1;
            end else begin
               overflow_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.word_data  = word_data_q;
   assign bus.word_valid = word_valid_q;
   assign bus.erasure    = erasure_q;
   assign bus.overflow   = overflow_q;
endmodule
